// File: rtl/counter_scan_ctrl.sv
// rtl/counter_scan_ctrl.sv - 2-D inner/outer step-counter scan sequencer with valid/ready beat output
//
// Purpose: on start_i, checks and latches inner/outer loop bounds, then emits one
// (inner, outer) coordinate pair per beat over a valid/ready handshake, inner loop
// fastest. Pulses done_o one cycle after the final handshake.
//
// Ports:
//   clk_i, rst_i             clock, asynchronous active-high reset
//   start_i                  scan request (sampled only in IDLE)
//   abort_i                  synchronous abort back to IDLE, no done_o
//   inner_start/end/step_i   inner loop config (end inclusive)
//   outer_start/end/step_i   outer loop config (end inclusive)
//   ready_i                  downstream accepts current beat
//   valid_o, inner_o, outer_o, last_o   beat outputs
//   busy_o                   scan in progress (RUN)
//   done_o                   one-cycle completion pulse
//   cfg_err_o                sticky flag for the last rejected start_i

module counter_scan_ctrl #(
  parameter int Bits = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [Bits-1:0] inner_start_i,
  input  logic [Bits-1:0] inner_end_i,
  input  logic [Bits-1:0] inner_step_i,
  input  logic [Bits-1:0] outer_start_i,
  input  logic [Bits-1:0] outer_end_i,
  input  logic [Bits-1:0] outer_step_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [Bits-1:0] inner_o,
  output logic [Bits-1:0] outer_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            cfg_err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [Bits-1:0] inner_q, inner_d;
  logic [Bits-1:0] outer_q, outer_d;
  logic [Bits-1:0] istart_q, istart_d;
  logic [Bits-1:0] iend_q, iend_d;
  logic [Bits-1:0] istep_q, istep_d;
  logic [Bits-1:0] oend_q, oend_d;
  logic [Bits-1:0] ostep_q, ostep_d;
  logic            cfg_err_q, cfg_err_d;

  logic            cfg_ok;
  logic [Bits:0]   inner_sum, outer_sum;
  logic            inner_wrap, outer_wrap;
  logic            run, hs;

  assign cfg_ok = (inner_end_i >= inner_start_i) && (inner_step_i != '0) &&
                  (outer_end_i >= outer_start_i) && (outer_step_i != '0);

  // One extra bit so a sum past the top of the range is never mistaken for a small value.
  assign inner_sum  = {1'b0, inner_q} + {1'b0, istep_q};
  assign outer_sum  = {1'b0, outer_q} + {1'b0, ostep_q};
  assign inner_wrap = inner_sum > {1'b0, iend_q};
  assign outer_wrap = outer_sum > {1'b0, oend_q};

  assign run = (state_q == S_RUN);
  assign hs  = run & ready_i;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      inner_q   <= '0;
      outer_q   <= '0;
      istart_q  <= '0;
      iend_q    <= '0;
      istep_q   <= '0;
      oend_q    <= '0;
      ostep_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      inner_q   <= inner_d;
      outer_q   <= outer_d;
      istart_q  <= istart_d;
      iend_q    <= iend_d;
      istep_q   <= istep_d;
      oend_q    <= oend_d;
      ostep_q   <= ostep_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Next-state logic. outer_start only seeds outer_q, so it needs no storage of its own.
  always_comb begin
    state_d   = state_q;
    inner_d   = inner_q;
    outer_d   = outer_q;
    istart_d  = istart_q;
    iend_d    = iend_q;
    istep_d   = istep_q;
    oend_d    = oend_q;
    ostep_d   = ostep_q;
    cfg_err_d = cfg_err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (cfg_ok) begin
            state_d   = S_RUN;
            cfg_err_d = 1'b0;
            inner_d   = inner_start_i;
            outer_d   = outer_start_i;
            istart_d  = inner_start_i;
            iend_d    = inner_end_i;
            istep_d   = inner_step_i;
            oend_d    = outer_end_i;
            ostep_d   = outer_step_i;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (hs) begin
          if (!inner_wrap) begin
            inner_d = inner_sum[Bits-1:0];
          end else if (!outer_wrap) begin
            inner_d = istart_q;
            outer_d = outer_sum[Bits-1:0];
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    valid_o   = run;
    busy_o    = run;
    done_o    = (state_q == S_DONE);
    last_o    = run & inner_wrap & outer_wrap;
    inner_o   = inner_q;
    outer_o   = outer_q;
    cfg_err_o = cfg_err_q;
  end

endmodule
